jk_bank_sched: RTL and testbench

Two-requester scheduler that shares a bank of WIDTH JK flip-flops. Each requester submits one command (hold/clear/set/toggle on one bit index) over a valid/ready handshake. A round-robin arbiter grants one requester at a time, and a three-state FSM drives the J/K inputs of the addressed flip-flop for exactly one clock, then acknowledges the requester. The block sits between software-style command sources and the flip-flop bank, and it is the only agent that drives the bank.

---
 rtl/jk_sched_pkg.sv | 27 ++
 rtl/jk_bank.sv | 43 ++++
 rtl/jk_bank_sched.sv | 125 ++++++++++++
 tb/tb_jk_bank_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_sched_pkg.sv
// Shared definitions for the JK bank scheduler: command opcodes, FSM states
// and the per-bit JK next-state rule.
package jk_sched_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_e;

    // The opcode encoding is {J,K}, so one rule serves both commands and flops.
    function automatic logic jk_next(input logic [1:0] jk, input logic q);
        case (jk)
            OP_HOLD: return q;
            OP_CLR:  return 1'b0;
            OP_SET:  return 1'b1;
            OP_TGL:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops, one jk_ff cell per bit, async active-low reset.
module jk_ff
    import jk_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q, q_d;

    always_comb q_d = jk_next({j, k}, q_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

module jk_bank #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    jk_ff u_ff [WIDTH-1:0] (
        .clk (clk),
        .rst (rst),
        .j   (j),
        .k   (k),
        .q   (q)
    );

endmodule

// File: rtl/jk_bank_sched.sv
// Two-requester round-robin scheduler that applies one JK command per grant to
// a shared flip-flop bank: IDLE (arbitrate) -> APPLY (drive J/K) -> ACK.
module jk_bank_sched
    import jk_sched_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [IDXW-1:0]  req0_idx,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [IDXW-1:0]  req1_idx,
    output logic             req1_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             grant,
    output logic             done,
    output logic             err
);

    typedef struct packed {
        logic [1:0]      op;
        logic [IDXW-1:0] idx;
    } cmd_t;

    localparam logic [IDXW:0] WIDTH_LIM = (IDXW + 1)'(WIDTH);

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic             grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic             sel;
    logic             idx_oob;
    cmd_t             cmd0, cmd1;
    logic [WIDTH-1:0] j_vec, k_vec;

    assign cmd0    = {req0_op, req0_idx};
    assign cmd1    = {req1_op, req1_idx};
    assign idx_oob = {1'b0, cmd_q.idx} >= WIDTH_LIM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // grant_q doubles as the latched source id of the command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q   <= '0;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        sel     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = APPLY;
                    grant_d = sel;
                    cmd_d   = sel ? cmd1 : cmd0;
                end
            end
            APPLY: state_d = ACK;
            ACK: begin
                state_d = IDLE;
                ptr_d   = ~grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // An out-of-range idx matches no bit, so the bank simply holds.
    always_comb begin
        j_vec      = '0;
        k_vec      = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            APPLY: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cmd_q.idx == IDXW'(i)) begin
                        j_vec[i] = cmd_q.op[1];
                        k_vec[i] = cmd_q.op[0];
                    end
                end
            end
            ACK: begin
                done       = 1'b1;
                err        = idx_oob;
                req0_ready = ~grant_q;
                req1_ready = grant_q;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;

    jk_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .rst (rst),
        .j   (j_vec),
        .k   (k_vec),
        .q   (q)
    );

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed command table, hand-written arbitration and
// reset sequences, then random traffic against a transaction-timing model.
module tb_jk_bank_sched;

    localparam int WIDTH = 6;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic [IDXW-1:0]  req0_idx = '0, req1_idx = '0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] q;
    logic             busy, grant, done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jk_bank_sched #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_idx   (req0_idx),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_idx   (req1_idx),
        .req1_ready (req1_ready),
        .q          (q),
        .busy       (busy),
        .grant      (grant),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        bit         src;
        logic [1:0] op;
        logic [2:0] idx;
        logic [5:0] exp_q;
        bit         exp_err;
    } vec_t;

    vec_t tbl[$];

    int         got_lat, got_cyc;
    logic [5:0] got_q;
    logic       got_r0, got_r1, got_done, got_err, got_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit s, input logic [1:0] op, input logic [2:0] idx,
                       input logic [5:0] eq, input bit ee);
        vec_t v;
        v.src = s; v.op = op; v.idx = idx; v.exp_q = eq; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit v0, input logic [1:0] op0, input logic [2:0] i0,
                         input bit v1, input logic [1:0] op1, input logic [2:0] i1);
        req0_valid = v0; req0_op = op0; req0_idx = i0;
        req1_valid = v1; req1_op = op1; req1_idx = i1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 2'b00, 3'd0, 0, 2'b00, 3'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One command from an idle scheduler; captures outputs in the ready cycle.
    task automatic do_cmd(input bit src, input logic [1:0] op, input logic [2:0] idx);
        @(negedge clk);
        if (src) drive(0, 2'b00, 3'd0, 1, op, idx);
        else     drive(1, op, idx, 0, 2'b00, 3'd0);
        got_lat = -1; got_q = 'x; got_r0 = 0; got_r1 = 0;
        got_done = 0; got_err = 0; got_grant = 'x; got_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got_lat = c; got_q = q; got_r0 = req0_ready; got_r1 = req1_ready;
                got_done = done; got_err = err; got_grant = grant; got_cyc = cyc;
                break;
            end
        end
        drive(0, 2'b00, 3'd0, 0, 2'b00, 3'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int prev_cyc;
        int order[4];
        int n_rdy;

        // Reset state
        @(negedge clk);
        check("rst_q", 32'(q), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        rst = 1'b1;

        // Directed command table (q accumulates from 0)
        add(0, 2'b10, 3'd2, 6'b000100, 0);
        add(1, 2'b11, 3'd2, 6'b000000, 0);
        add(1, 2'b11, 3'd5, 6'b100000, 0);
        add(0, 2'b10, 3'd0, 6'b100001, 0);
        add(1, 2'b10, 3'd1, 6'b100011, 0);
        add(0, 2'b10, 3'd2, 6'b100111, 0);
        add(1, 2'b10, 3'd3, 6'b101111, 0);
        add(0, 2'b10, 3'd4, 6'b111111, 0);
        add(0, 2'b01, 3'd3, 6'b110111, 0);
        add(0, 2'b00, 3'd4, 6'b110111, 0);
        add(1, 2'b10, 3'd7, 6'b110111, 1);
        add(0, 2'b01, 3'd6, 6'b110111, 1);
        add(1, 2'b01, 3'd5, 6'b010111, 0);
        add(0, 2'b11, 3'd0, 6'b010110, 0);
        add(1, 2'b11, 3'd0, 6'b010111, 0);

        prev_cyc = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            do_cmd(tbl[i].src, tbl[i].op, tbl[i].idx);
            check($sformatf("v%0d_lat", i), 32'(got_lat), 32'd2);
            check($sformatf("v%0d_q", i), 32'(got_q), 32'(tbl[i].exp_q));
            check($sformatf("v%0d_ready", i), 32'({got_r0, got_r1}),
                  tbl[i].src ? 32'b01 : 32'b10);
            check($sformatf("v%0d_done", i), 32'(got_done), 32'd1);
            check($sformatf("v%0d_err", i), 32'(got_err), 32'(tbl[i].exp_err));
            check($sformatf("v%0d_grant", i), 32'(got_grant), 32'(tbl[i].src));
            if (i > 0) check($sformatf("v%0d_gap", i), 32'(got_cyc - prev_cyc), 32'd3);
            prev_cyc = got_cyc;
        end
        @(negedge clk);
        check("oob_idle", 32'({busy, done, err}), 32'd0);

        // Both requesters held valid: strict alternation starting at req0
        do_reset();
        @(negedge clk);
        drive(1, 2'b10, 3'd0, 1, 2'b10, 3'd1);
        n_rdy = 0;
        prev_cyc = -1;
        for (int c = 0; c < 20 && n_rdy < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) check("alt_both_ready", 32'd1, 32'd0);
            if (req0_ready || req1_ready) begin
                order[n_rdy] = req1_ready ? 1 : 0;
                check($sformatf("alt%0d_grant", n_rdy), 32'(grant), 32'(n_rdy % 2));
                if (prev_cyc >= 0)
                    check($sformatf("alt%0d_gap", n_rdy), 32'(cyc - prev_cyc), 32'd3);
                prev_cyc = cyc;
                n_rdy++;
            end
        end
        drive(0, 2'b00, 3'd0, 0, 2'b00, 3'd0);
        check("alt_count", 32'(n_rdy), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < n_rdy) check($sformatf("alt%0d_order", k), 32'(order[k]), 32'(k % 2));
        check("alt_q", 32'(q), 32'b000011);

        // Reset asserted during APPLY
        do_reset();
        @(negedge clk);
        drive(1, 2'b10, 3'd1, 0, 2'b00, 3'd0);
        @(negedge clk);
        check("mid_busy_apply", 32'(busy), 32'd1);
        rst = 1'b0;
        drive(1, 2'b10, 3'd3, 1, 2'b10, 3'd4);
        #1;
        check("mid_rst_q", 32'(q), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("mid_rst_noready", 32'({req0_ready, req1_ready, done}), 32'd0);
        check("mid_rst_q2", 32'(q), 32'd0);
        rst = 1'b1;
        got_lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got_lat = c;
                check("mid_first_ready", 32'({req0_ready, req1_ready}), 32'b10);
                check("mid_first_grant", 32'(grant), 32'd0);
                check("mid_first_q", 32'(q), 32'b001000);
                break;
            end
        end
        check("mid_first_lat", 32'(got_lat), 32'd2);
        drive(0, 2'b00, 3'd0, 0, 2'b00, 3'd0);

        // Random traffic against a transaction-timing reference model
        do_reset();
        begin : rnd
            int         free_at, sel_t, ack_t, midx;
            bit         msrc, mptr, mgrant, e_busy, e_r0, e_r1, e_err;
            logic [1:0] mop;
            logic [5:0] mq;
            bit         act[2];
            logic [1:0] aop[2];
            logic [2:0] aidx[2];
            bit         rdy;
            free_at = 0; sel_t = -100; ack_t = -100; midx = 0;
            msrc = 0; mptr = 0; mgrant = 0; mop = '0; mq = '0;
            act[0] = 0; act[1] = 0;
            aop[0] = '0; aop[1] = '0; aidx[0] = '0; aidx[1] = '0;
            for (int t = 0; t < 400; t++) begin
                @(negedge clk);
                if (t == ack_t && midx < WIDTH) begin
                    case (mop)
                        2'b01: mq[midx] = 1'b0;
                        2'b10: mq[midx] = 1'b1;
                        2'b11: mq[midx] = ~mq[midx];
                        default: ;
                    endcase
                end
                if (t == sel_t + 1) mgrant = msrc;
                e_busy = (t > sel_t) && (t <= ack_t);
                e_r0   = (t == ack_t) && !msrc;
                e_r1   = (t == ack_t) && msrc;
                e_err  = (t == ack_t) && (midx >= WIDTH);
                check("rnd_q", 32'(q), 32'(mq));
                check("rnd_r0", 32'(req0_ready), 32'(e_r0));
                check("rnd_r1", 32'(req1_ready), 32'(e_r1));
                check("rnd_done", 32'(done), 32'(e_r0 || e_r1));
                check("rnd_err", 32'(err), 32'(e_err));
                check("rnd_busy", 32'(busy), 32'(e_busy));
                check("rnd_grant", 32'(grant), 32'(mgrant));
                if (t == ack_t) mptr = !msrc;
                for (int i = 0; i < 2; i++) begin
                    rdy = (i == 1) ? req1_ready : req0_ready;
                    if (act[i] && rdy) act[i] = 0;
                    if (!act[i] && $urandom_range(0, 2) != 0) begin
                        act[i]  = 1;
                        aop[i]  = 2'($urandom_range(0, 3));
                        aidx[i] = 3'($urandom_range(0, 7));
                    end
                end
                drive(act[0], aop[0], aidx[0], act[1], aop[1], aidx[1]);
                if (t >= free_at && (act[0] || act[1])) begin
                    msrc    = (act[0] && act[1]) ? mptr : act[1];
                    mop     = aop[msrc];
                    midx    = int'(aidx[msrc]);
                    sel_t   = t;
                    ack_t   = t + 2;
                    free_at = t + 3;
                end
            end
        end
        drive(0, 2'b00, 3'd0, 0, 2'b00, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
